// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Moore multi-cycle control sequencer for the single-datapath MIPS
//            core. Steps each instruction through fetch, decode, execute,
//            memory and write-back. Waits on a bounded MemReady handshake,
//            counts retired instructions, and halts on illegal opcodes or a
//            memory timeout.
// Options  : MC_BRANCH_EN - when defined, beq (opcode 4) is executed through
//            the BRANCH state; otherwise it is treated as an illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [5:0]  opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic [3:0]  State,
    output logic [31:0] InstrCount,
    output logic        IllegalOp,
    output logic        Timeout
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_LW    = 4'd8,
`ifdef MC_BRANCH_EN
        BRANCH   = 4'd9,
`endif
        HALT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;
`ifdef MC_BRANCH_EN
    localparam logic [5:0] OP_BEQ    = 6'd4;
`endif
    // Last wait count at which a missing MemReady still counts as in time.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] count_q, count_d;
    logic        illegal_q, illegal_d;
    logic        timeout_q, timeout_d;

`ifndef MC_BRANCH_EN
    // Zero only steers the branch state, which this build leaves out.
    logic unused_zero;
    assign unused_zero = Zero;
`endif

    // State, counters and sticky flags; active-low reset wins over everything.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            count_q   <= 32'd0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state, wait counter, retire counter and halt-flag logic.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        count_d   = count_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (opcode == OP_RTYPE) begin
                    state_d = EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = MEM_ADDR;
`ifdef MC_BRANCH_EN
                end else if (opcode == OP_BEQ) begin
                    state_d = BRANCH;
`endif
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC_R: state_d = WB_R;
            WB_R: begin
                state_d = FETCH;
                count_d = count_q + 32'd1;
            end
            MEM_ADDR: begin
                // Clearing here means the count starts at 0 on memory-state entry.
                wait_d  = 8'd0;
                state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                if (MemReady) begin
                    state_d = WB_LW;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            MEM_WR: begin
                if (MemReady) begin
                    state_d = FETCH;
                    count_d = count_q + 32'd1;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = HALT;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            WB_LW: begin
                state_d = FETCH;
                count_d = count_q + 32'd1;
            end
`ifdef MC_BRANCH_EN
            BRANCH: begin
                state_d = FETCH;
                count_d = count_q + 32'd1;
            end
`endif
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Moore output decode; only PCWrite in BRANCH looks at an input (Zero).
    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUOp    = 2'b00;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            EXEC_R: ALUOp = 2'b10;
            WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                MemtoReg = 1'b1;
                ALUOp    = 2'b10;
            end
            MEM_ADDR: ALUSrc = 1'b1;
            MEM_RD: begin
                MemRead = 1'b1;
                ALUSrc  = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                ALUSrc   = 1'b1;
            end
            WB_LW: RegWrite = 1'b1;
`ifdef MC_BRANCH_EN
            BRANCH: begin
                ALUOp   = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = Zero;
            end
`endif
            default: ;
        endcase
    end

    assign State      = state_q;
    assign InstrCount = count_q;
    assign IllegalOp  = illegal_q;
    assign Timeout    = timeout_q;

endmodule
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the single-datapath MIPS core. It replaces the per-opcode combinational control decode with a Moore state machine. The FSM steps each instruction through fetch, decode, execute, memory and write-back, and drives every datapath enable: PC, instruction register, register file, ALU control, muxes and data memory. It waits on a data-memory ready handshake with a bounded timeout, counts retired instructions, and halts on illegal opcodes.

## Interface
- WAIT_MAX, 15, maximum cycles a memory state waits for MemReady before timeout (1..255)
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous reset, active-low
- opcode  input  6  instruction[31:26] from instruction register
- Zero  input  1  ALU zero flag
- MemReady  input  1  data memory completion strobe for current access
- PCWrite  output  1  load PC
- PCSrc  output  1  0 = PC+4, 1 = branch target
- IRWrite  output  1  load instruction register
- RegWrite  output  1  register file write enable
- RegDst  output  1  1 = rd, 0 = rt
- ALUSrc  output  1  1 = sign-extended immediate, 0 = ReadData2
- MemtoReg  output  1  datapath convention: 1 = ALUOut, 0 = memory data
- MemRead  output  1  data memory read request
- MemWrite  output  1  data memory write request
- ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded
- State  output  4  current state encoding, for debug
- InstrCount  output  32  retired-instruction counter
- IllegalOp  output  1  sticky: halted on unsupported opcode
- Timeout  output  1  sticky: halted on MemReady timeout

## Operation
State encodings and outputs. Any output not listed for a state is 0.
- IDLE=0: all outputs 0. Goes to FETCH on the next cycle.
- FETCH=1: IRWrite=1, PCWrite=1, PCSrc=0. Goes to DECODE.
- DECODE=2: all outputs 0 while registers are read.
  - opcode 0 → EXEC_R
  - opcode 35 or 43 → MEM_ADDR
  - opcode 4 → BRANCH (only if MC_BRANCH_EN is defined)
  - anything else → HALT with IllegalOp set to 1
- EXEC_R=3: ALUOp=10, ALUSrc=0. Goes to WB_R.
- WB_R=4: RegWrite=1, RegDst=1, MemtoReg=1, ALUOp=10. Goes to FETCH; the instruction retires.
- MEM_ADDR=5: ALUSrc=1, ALUOp=00. Goes to MEM_RD for opcode 35, MEM_WR for opcode 43.
- MEM_RD=6: MemRead=1, ALUSrc=1, ALUOp=00. Held until MemReady=1, then goes to WB_LW.
- MEM_WR=7: MemWrite=1, ALUSrc=1, ALUOp=00. Held until MemReady=1, then goes to FETCH and retires.
- WB_LW=8: RegWrite=1, RegDst=0, MemtoReg=0. Goes to FETCH and retires.
- BRANCH=9: ALUOp=01, ALUSrc=0, PCSrc=1, PCWrite=Zero. Goes to FETCH and retires.
- HALT=15: all outputs 0. Stays in HALT until reset.

Opcode handling:
- opcode is sampled only in DECODE and MEM_ADDR.
- The instruction register holds opcode stable from FETCH until the next FETCH.

Retired-instruction counter:
- InstrCount increments by 1 on each transition into FETCH from WB_R, WB_LW, MEM_WR or BRANCH.
- It wraps from 0xFFFFFFFF to 0.

Memory wait counter:
- 8-bit, cleared on entry to MEM_RD or MEM_WR, incremented each cycle the FSM remains there with MemReady=0.
- If MemReady=0 and the count equals WAIT_MAX-1, the next state is HALT with Timeout set to 1.
- If MemReady=1 on that same cycle, the access completes normally. MemReady takes priority over timeout.

## Timing
Reset:
- RESET=0 at a rising edge forces State=IDLE, InstrCount=0, wait count 0, IllegalOp=0, Timeout=0.
- Reset overrides every other transition, including from HALT and mid-memory-access. No write completes after a reset edge.

Outputs:
- All outputs are a pure decode of the state register (Moore), so they are valid the whole cycle.
- There is no combinational path from any input to any output, except PCWrite in BRANCH, which follows Zero.

Cycles per instruction (FETCH through final state inclusive, MemReady on first cycle):
- R-type: 4
- sw: 4
- lw: 5
- beq: 3

Memory handshake:
- Each cycle MemReady=0 adds one cycle.
- MemRead/MemWrite stay high continuously until the cycle in which MemReady=1 is sampled. They deassert on the following cycle.
- MemReady outside MEM_RD/MEM_WR is ignored.

## Configuration
- MC_BRANCH_EN defined: opcode 4 (beq) is decoded to BRANCH as specified above.
- MC_BRANCH_EN undefined: the BRANCH state is not built, and opcode 4 goes to HALT with IllegalOp=1 like any unsupported opcode.

## Test plan
- Reset, then opcode=0 held: states 0,1,2,3,4,1,...; RegWrite=1 only in WB_R cycles; InstrCount=3 after 13 cycles from reset release.
- opcode=35, MemReady low for 3 cycles in MEM_RD: MemRead high 4 cycles, then WB_LW with RegDst=0, MemtoReg=0; lw takes 8 cycles.
- opcode=43, MemReady never asserted, WAIT_MAX=15: MemWrite high exactly 15 cycles, then State=15, Timeout=1, all enables 0.
- opcode=2: DECODE → HALT, IllegalOp=1, InstrCount unchanged. RESET=0 for one edge → State=0, flags 0.
- With MC_BRANCH_EN, opcode=4: Zero=1 gives PCWrite=1, PCSrc=1 in BRANCH; Zero=0 gives PCWrite=0. Without the macro, opcode=4 → IllegalOp=1.
- RESET=0 asserted during MEM_RD with MemReady=1 on the same edge: State=IDLE, WB_LW never entered, InstrCount=0.
